// File: rtl/curl_pow_seq.sv
// Job sequencer for the Curl PoW core: resets the core, streams state words into it,
// runs the absorb transforms and the final PoW, and collects the nonce or aborts on iteration limit.
module curl_pow_seq #(
  parameter int NUM_BLOCKS = 33,
  parameter int RST_CYCLES = 2,
  parameter int ITER_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_start,
  input  logic [31:0]       i_mwm_mask,
  input  logic [ITER_W-1:0] i_max_iter,
  input  logic              i_word_valid,
  input  logic [53:0]       i_word,
  output logic              o_word_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic [161:0]      o_nonce,
  output logic [ITER_W-1:0] o_iter_cnt,
  output logic              o_core_arst_n,
  output logic              o_core_we,
  output logic [3:0]        o_core_addr,
  output logic [53:0]       o_core_data,
  output logic              o_core_transform,
  output logic              o_core_pow,
  output logic [31:0]       o_core_mwm_mask,
  input  logic              i_core_transforming,
  input  logic              i_core_pow_finish,
  input  logic              i_core_pow_hash_finish,
  input  logic [161:0]      i_core_data
);

  localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CORE_RST, S_LOAD, S_TRANSFORM, S_TF_WAIT, S_POW, S_POW_WAIT, S_ABORT_RST
  } state_t;

  state_t            state_reg;
  logic [31:0]       mask_reg;
  logic [ITER_W-1:0] max_iter_reg;
  logic [ITER_W-1:0] iter_reg;
  logic [ITER_W-1:0] iter_inc;
  logic [BLK_W-1:0]  blk_reg;
  logic [3:0]        word_reg;
  logic [RC_W-1:0]   rst_cnt_reg;
  logic              seen_reg;
  logic [161:0]      nonce_reg;
  logic              done_reg;
  logic              timeout_reg;
  logic              released_reg;
  logic              load_st;
  logic              word_accept;

  assign load_st     = (state_reg == S_LOAD);
  assign word_accept = load_st & i_word_valid;
  assign iter_inc    = (iter_reg == {ITER_W{1'b1}}) ? iter_reg : iter_reg + ITER_W'(1);

  // released_reg keeps the core in reset for the first cycle after our own reset is released.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_reg    <= S_IDLE;
      mask_reg     <= '0;
      max_iter_reg <= '0;
      iter_reg     <= '0;
      blk_reg      <= '0;
      word_reg     <= '0;
      rst_cnt_reg  <= '0;
      seen_reg     <= 1'b0;
      nonce_reg    <= '0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      released_reg <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      released_reg <= 1'b1;
      case (state_reg)
        S_IDLE: begin
          if (i_start) begin
            mask_reg     <= i_mwm_mask;
            max_iter_reg <= i_max_iter;
            iter_reg     <= '0;
            blk_reg      <= '0;
            word_reg     <= '0;
            rst_cnt_reg  <= '0;
            seen_reg     <= 1'b0;
            state_reg    <= S_CORE_RST;
          end
        end
        S_CORE_RST, S_ABORT_RST: begin
          if (rst_cnt_reg == RST_LAST) begin
            rst_cnt_reg <= '0;
            state_reg   <= (state_reg == S_CORE_RST) ? S_LOAD : S_IDLE;
          end else begin
            rst_cnt_reg <= rst_cnt_reg + 1'b1;
          end
        end
        S_LOAD: begin
          if (word_accept) begin
            if (word_reg == 4'd8) begin
              word_reg  <= '0;
              state_reg <= (blk_reg < LAST_BLK) ? S_TRANSFORM : S_POW;
            end else begin
              word_reg <= word_reg + 1'b1;
            end
          end
        end
        S_TRANSFORM: begin
          seen_reg  <= 1'b0;
          state_reg <= S_TF_WAIT;
        end
        S_TF_WAIT: begin
          // Wait for a full high-then-low cycle of the core's transforming flag.
          if (i_core_transforming) begin
            seen_reg <= 1'b1;
          end else if (seen_reg) begin
            seen_reg  <= 1'b0;
            blk_reg   <= blk_reg + 1'b1;
            state_reg <= S_LOAD;
          end
        end
        S_POW: begin
          state_reg <= S_POW_WAIT;
        end
        S_POW_WAIT: begin
          if (i_core_pow_hash_finish) begin
            iter_reg <= iter_inc;
          end
          if (i_core_pow_finish) begin
            nonce_reg <= i_core_data;
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end else if (i_core_pow_hash_finish && (max_iter_reg != '0) && (iter_inc == max_iter_reg)) begin
            timeout_reg <= 1'b1;
            state_reg   <= S_ABORT_RST;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign o_word_ready     = load_st;
  assign o_busy           = (state_reg != S_IDLE);
  assign o_done           = done_reg;
  assign o_timeout        = timeout_reg;
  assign o_nonce          = nonce_reg;
  assign o_iter_cnt       = iter_reg;
  assign o_core_arst_n    = released_reg & (state_reg != S_CORE_RST) & (state_reg != S_ABORT_RST);
  assign o_core_we        = word_accept;
  assign o_core_addr      = word_reg;
  assign o_core_data      = i_word;
  assign o_core_transform = (state_reg == S_TRANSFORM);
  assign o_core_pow       = (state_reg == S_POW);
  assign o_core_mwm_mask  = mask_reg;

endmodule

// File: tb/tb_curl_pow_seq.sv
// Randomised bench for curl_pow_seq: a behavioural core/host model drives the DUT and a
// cycle-level expectation model, updated from observed traffic, is compared every cycle.
module tb_curl_pow_seq;
  localparam int NB     = 3;
  localparam int RC     = 2;
  localparam int IW     = 32;
  localparam int TF_LEN = 81;

  logic          clk = 1'b0;
  logic          i_arst = 1'b1;
  logic          i_start = 1'b0;
  logic [31:0]   i_mwm_mask = '0;
  logic [IW-1:0] i_max_iter = '0;
  logic          i_word_valid = 1'b0;
  logic [53:0]   i_word = '0;
  logic          o_word_ready, o_busy, o_done, o_timeout;
  logic [161:0]  o_nonce;
  logic [IW-1:0] o_iter_cnt;
  logic          o_core_arst_n, o_core_we, o_core_transform, o_core_pow;
  logic [3:0]    o_core_addr;
  logic [53:0]   o_core_data;
  logic [31:0]   o_core_mwm_mask;
  logic          core_transforming = 1'b0, core_pow_finish = 1'b0, core_pow_hash_finish = 1'b0;
  logic [161:0]  core_data = '0;

  curl_pow_seq #(.NUM_BLOCKS(NB), .RST_CYCLES(RC), .ITER_W(IW)) dut (
    .i_clk(clk), .i_arst(i_arst), .i_start(i_start), .i_mwm_mask(i_mwm_mask),
    .i_max_iter(i_max_iter), .i_word_valid(i_word_valid), .i_word(i_word),
    .o_word_ready(o_word_ready), .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
    .o_nonce(o_nonce), .o_iter_cnt(o_iter_cnt), .o_core_arst_n(o_core_arst_n),
    .o_core_we(o_core_we), .o_core_addr(o_core_addr), .o_core_data(o_core_data),
    .o_core_transform(o_core_transform), .o_core_pow(o_core_pow),
    .o_core_mwm_mask(o_core_mwm_mask), .i_core_transforming(core_transforming),
    .i_core_pow_finish(core_pow_finish), .i_core_pow_hash_finish(core_pow_hash_finish),
    .i_core_data(core_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Host word source and core behaviour, both driven 1 time unit after the rising edge.
  int valid_mode = 0;
  int fin_on = 0;
  logic [161:0] last_nonce = '0;

  always @(posedge clk) begin
    logic [63:0] r;
    #1;
    r = {$urandom, $urandom};
    i_word = r[53:0];
    case (valid_mode)
      0: i_word_valid = 1'b1;
      1: i_word_valid = ~i_word_valid;
      default: i_word_valid = ($urandom_range(0, 2) != 0);
    endcase
  end

  int tf_cnt = 0;
  bit pow_act = 0;
  int hashes = 0;
  int gap = 0;
  always @(posedge clk) begin
    logic [191:0] r;
    #1;
    core_pow_hash_finish = 1'b0;
    core_pow_finish = 1'b0;
    if (!o_core_arst_n) begin
      tf_cnt = 0;
      pow_act = 0;
      core_transforming = 1'b0;
    end else begin
      if (tf_cnt > 0) begin core_transforming = 1'b1; tf_cnt--; end
      else core_transforming = 1'b0;
      if (pow_act) begin
        gap--;
        if (gap == 0) begin
          core_pow_hash_finish = 1'b1;
          hashes++;
          gap = $urandom_range(1, 3);
          if (hashes == fin_on) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            core_data = r[161:0];
            last_nonce = r[161:0];
            core_pow_finish = 1'b1;
            pow_act = 0;
          end
        end
      end
      if (o_core_transform) tf_cnt = TF_LEN;
      if (o_core_pow) begin pow_act = 1; hashes = 0; gap = $urandom_range(1, 3); end
    end
  end

  // Expectation model: job phase, words accepted this job, transforms issued, hashes counted.
  typedef enum {P_IDLE, P_RST, P_LOAD, P_TFC, P_TFW, P_POWC, P_POWW, P_ABORT} phase_t;
  phase_t        m_phase = P_IDLE;
  int            m_rst_left = 0;
  int            m_words = 0;
  int            m_tf = 0;
  bit            m_seen = 0;
  logic [IW-1:0] m_iter = '0;
  logic [IW-1:0] m_max = '0;
  logic [161:0]  m_nonce = '0;
  logic [31:0]   m_mask = '0;
  bit            m_done = 0, m_to = 0, m_rel_low = 1;
  int n_we = 0, n_tf = 0, n_pow = 0, n_done = 0, n_to = 0, n_abort_low = 0;

  always @(negedge clk) begin
    logic [IW-1:0] n;
    bit exp_we;
    if (i_arst) begin
      m_phase = P_IDLE; m_iter = '0; m_nonce = '0; m_mask = '0;
      m_done = 0; m_to = 0; m_rel_low = 1; m_words = 0; m_tf = 0;
    end
    exp_we = (m_phase == P_LOAD) && i_word_valid;
    chk("busy", 162'(o_busy), 162'(m_phase != P_IDLE));
    chk("word_ready", 162'(o_word_ready), 162'(m_phase == P_LOAD));
    chk("core_we", 162'(o_core_we), 162'(exp_we));
    if (exp_we) begin
      chk("core_addr", 162'(o_core_addr), 162'(m_words % 9));
      chk("core_data", 162'(o_core_data), 162'(i_word));
    end
    chk("core_transform", 162'(o_core_transform), 162'(m_phase == P_TFC));
    chk("core_pow", 162'(o_core_pow), 162'(m_phase == P_POWC));
    chk("core_arst_n", 162'(o_core_arst_n),
        162'(!(i_arst || m_rel_low || m_phase == P_RST || m_phase == P_ABORT)));
    chk("done", 162'(o_done), 162'(m_done));
    chk("timeout", 162'(o_timeout), 162'(m_to));
    chk("iter_cnt", 162'(o_iter_cnt), 162'(m_iter));
    chk("nonce", o_nonce, m_nonce);
    chk("mwm_mask", 162'(o_core_mwm_mask), 162'(m_mask));
    if (o_core_we) n_we++;
    if (o_core_transform) n_tf++;
    if (o_core_pow) n_pow++;
    if (o_done) n_done++;
    if (o_timeout) n_to++;
    if (!o_core_arst_n && m_phase == P_ABORT) n_abort_low++;

    if (!i_arst) begin
      m_rel_low = 0; m_done = 0; m_to = 0;
      case (m_phase)
        P_IDLE: if (i_start) begin
          m_mask = i_mwm_mask; m_max = i_max_iter; m_iter = '0;
          m_words = 0; m_tf = 0; m_rst_left = RC; m_phase = P_RST;
        end
        P_RST: begin m_rst_left--; if (m_rst_left == 0) m_phase = P_LOAD; end
        P_LOAD: if (i_word_valid) begin
          m_words++;
          if (m_words % 9 == 0) m_phase = (m_tf < NB - 1) ? P_TFC : P_POWC;
        end
        P_TFC: begin m_tf++; m_seen = 0; m_phase = P_TFW; end
        P_TFW: if (core_transforming) m_seen = 1; else if (m_seen) m_phase = P_LOAD;
        P_POWC: m_phase = P_POWW;
        P_POWW: begin
          n = m_iter;
          if (core_pow_hash_finish && m_iter != '1) n = m_iter + 1;
          m_iter = n;
          if (core_pow_finish) begin
            m_nonce = core_data; m_done = 1; m_phase = P_IDLE;
          end else if (core_pow_hash_finish && m_max != 0 && n == m_max) begin
            m_to = 1; m_rst_left = RC; m_phase = P_ABORT;
          end
        end
        P_ABORT: begin m_rst_left--; if (m_rst_left == 0) m_phase = P_IDLE; end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic start_job(input logic [31:0] mask, input logic [IW-1:0] maxi,
                           input int fin, input int vmode);
    fin_on = fin;
    valid_mode = vmode;
    i_mwm_mask = mask;
    i_max_iter = maxi;
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
  endtask

  task automatic wait_job_end(input string name);
    int s;
    bit ok;
    s = n_done + n_to;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      if ((n_done + n_to) != s) begin ok = 1; break; end
    end
    chk({name, "_ended"}, 162'(ok), 162'(1));
    for (int i = 0; i < 10 && o_busy; i++) cyc(1);
  endtask

  // Runs one job and checks its totals against values derived from the job parameters.
  task automatic job(input string name, input logic [IW-1:0] maxi, input int fin, input int vmode);
    int we0, tf0, pw0, dn0, to0, ab0;
    bit exp_done;
    logic [31:0] mask;
    mask = $urandom;
    we0 = n_we; tf0 = n_tf; pw0 = n_pow; dn0 = n_done; to0 = n_to; ab0 = n_abort_low;
    exp_done = (fin != 0) && (maxi == 0 || fin <= int'(maxi));
    start_job(mask, maxi, fin, vmode);
    wait_job_end(name);
    chk({name, "_writes"}, 162'(n_we - we0), 162'(9 * NB));
    chk({name, "_transforms"}, 162'(n_tf - tf0), 162'(NB - 1));
    chk({name, "_pows"}, 162'(n_pow - pw0), 162'(1));
    chk({name, "_dones"}, 162'(n_done - dn0), 162'(exp_done));
    chk({name, "_timeouts"}, 162'(n_to - to0), 162'(!exp_done));
    chk({name, "_iter"}, 162'(o_iter_cnt), exp_done ? 162'(fin) : 162'(maxi));
    chk({name, "_mask"}, 162'(o_core_mwm_mask), 162'(mask));
    if (exp_done) chk({name, "_nonce"}, o_nonce, last_nonce);
    else chk({name, "_abort_low"}, 162'(n_abort_low - ab0), 162'(RC));
    $display("job %s max=%0d fin=%0d vmode=%0d iter=%0d done=%0d", name, maxi, fin, vmode,
             o_iter_cnt, exp_done);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int dn0, to0, mx, fn;
    logic [31:0] mask_d;
    cyc(3);
    i_arst = 1'b0;
    cyc(2);
    chk("post_reset_iter", 162'(o_iter_cnt), 162'(0));
    chk("post_reset_nonce", o_nonce, 162'(0));

    job("full", 0, 2, 0);
    chk("full_iter_literal", 162'(o_iter_cnt), 162'(2));
    job("toggle", 0, 3, 1);
    job("timeout4", 4, 0, 2);
    chk("timeout_iter_literal", 162'(o_iter_cnt), 162'(4));

    // Start pulsed while PoW is running must be ignored; finish and limit coincide on hash 3.
    dn0 = n_done; to0 = n_to;
    mask_d = 32'hA5A5_0F0F;
    start_job(mask_d, 3, 3, 0);
    for (int i = 0; i < 3000 && o_core_pow !== 1'b1; i++) cyc(1);
    cyc(1);
    i_mwm_mask = 32'h1234_5678;
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
    chk("mask_held", 162'(o_core_mwm_mask), 162'(mask_d));
    wait_job_end("coincide");
    chk("coincide_done", 162'(n_done - dn0), 162'(1));
    chk("coincide_no_timeout", 162'(n_to - to0), 162'(0));
    chk("coincide_iter", 162'(o_iter_cnt), 162'(3));
    $display("job coincide max=3 fin=3 done=%0d timeout=%0d", n_done - dn0, n_to - to0);

    job("unlimited300", 0, 300, 0);

    // Reset in the middle of loading abandons the job without any pulse.
    dn0 = n_done; to0 = n_to;
    start_job(32'hDEAD_BEEF, 0, 1, 0);
    cyc(RC + 4);
    i_arst = 1'b1;
    cyc(3);
    chk("rst_busy", 162'(o_busy), 162'(0));
    chk("rst_core_arst_n", 162'(o_core_arst_n), 162'(0));
    chk("rst_mask", 162'(o_core_mwm_mask), 162'(0));
    i_arst = 1'b0;
    cyc(3);
    chk("rst_no_pulses", 162'((n_done - dn0) + (n_to - to0)), 162'(0));
    $display("reset mid-load: busy=%0d mask=%0h", o_busy, o_core_mwm_mask);
    job("after_reset", 0, 1, 2);

    for (int j = 0; j < 4; j++) begin
      mx = $urandom_range(0, 5);
      fn = $urandom_range(0, 6);
      if (mx == 0 && fn == 0) fn = 3;
      job("random", IW'(mx), fn, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
